// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between fetch (producer), the fetch/decode queue and
// decode (consumer). The master side is the fetch/decode pipeline logic
// around the queue; the slave side is the queue itself.
interface fetch_decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Fetch side
    logic              in_valid;
    logic [31:0]       in_pc;
    logic [31:0]       in_instr;
    logic              in_ready;

    // Decode side
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic              out_is_ctrl;
    logic              out_ready;

    // Occupancy, 0..DEPTH
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_is_ctrl, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_is_ctrl, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry valid/ready FIFO
// of {pc, instr} pairs with single-cycle flush on a taken redirect and a
// control-transfer predecode of the head instruction.
module fetch_decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    fetch_decode_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    entry_t            head;

    // True for opcodes that redirect control flow (BRANCH, JAL, JALR)
    function automatic logic is_ctrl_op(input logic [31:0] instr);
        return (instr[6:0] == OPC_BRANCH) ||
               (instr[6:0] == OPC_JAL)    ||
               (instr[6:0] == OPC_JALR);
    endfunction

    // Occupancy flags and handshake qualifiers; out_ready is ignored when empty
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        push  = bus.in_valid  & ~full;
        pop   = bus.out_ready & ~empty;
    end

    // Entry storage write on an accepted push
    // NOTE: the storage array has no reset; entries are only observable once
    // count covers them, so clearing it would cost logic for no visible effect.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head presentation: combinational from rd_ptr, NOP-forced when empty
    // NOTE: every output gets a default before the conditional override so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        head            = mem[rd_ptr];
        bus.in_ready    = ~full;
        bus.out_valid   = ~empty;
        bus.count       = count_q;
        bus.out_pc      = '0;
        bus.out_instr   = NOP_INSTR;
        bus.out_is_ctrl = 1'b0;
        if (!empty) begin
            bus.out_pc      = head.pc;
            bus.out_instr   = head.instr;
            bus.out_is_ctrl = is_ctrl_op(head.instr);
        end
    end

    // Occupancy never exceeds DEPTH
    a_count_bound : assert property (
        @(posedge clk) disable iff (reset) count_q <= FULL_COUNT
    );

    // Pointer distance always agrees with the occupancy counter
    a_ptr_count : assert property (
        @(posedge clk) disable iff (reset)
            PTR_W'(wr_ptr - rd_ptr) == count_q[PTR_W-1:0]
    );

    // A push is never accepted while full
    a_no_push_full : assert property (
        @(posedge clk) disable iff (reset) full |-> !push
    );
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: accepted pushes go into a model
// queue, every cycle the head/flags/count are compared against the model.
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic exp_ctrl(input logic [31:0] instr);
        logic [6:0] opc;
        opc = instr[6:0];
        return (opc == 7'h63) || (opc == 7'h6F) || (opc == 7'h67);
    endfunction

    // One clock of stimulus with scoreboard comparison at the negedge
    task automatic run_cycle(input logic iv, input logic [31:0] pc,
                             input logic [31:0] instr, input logic ordy,
                             input logic fl, output logic pushed,
                             output logic popped);
        logic [63:0] head;
        logic        exp_ready;
        logic        exp_valid;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        exp_ready = (exp_q.size() != DEPTH);
        exp_valid = (exp_q.size() != 0);
        head      = exp_valid ? exp_q[0] : {32'h0, 32'h0000_0013};
        n_checks++;
        if (bus.in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, bus.in_ready, exp_ready);
        end
        n_checks++;
        if (bus.out_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL sb_out_valid t=%0t got %b exp %b", $time, bus.out_valid, exp_valid);
        end
        n_checks++;
        if (bus.count !== CNT_W'(exp_q.size())) begin
            n_fail++;
            $display("FAIL sb_count t=%0t got %0d exp %0d", $time, bus.count, exp_q.size());
        end
        n_checks++;
        if (bus.out_pc !== head[63:32]) begin
            n_fail++;
            $display("FAIL sb_out_pc t=%0t got %h exp %h", $time, bus.out_pc, head[63:32]);
        end
        n_checks++;
        if (bus.out_instr !== head[31:0]) begin
            n_fail++;
            $display("FAIL sb_out_instr t=%0t got %h exp %h", $time, bus.out_instr, head[31:0]);
        end
        n_checks++;
        if (bus.out_is_ctrl !== (exp_valid && exp_ctrl(head[31:0]))) begin
            n_fail++;
            $display("FAIL sb_is_ctrl t=%0t got %b exp %b", $time, bus.out_is_ctrl,
                     exp_valid && exp_ctrl(head[31:0]));
        end
        pushed = iv && exp_ready && !fl;
        popped = ordy && exp_valid && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (popped) void'(exp_q.pop_front());
            if (pushed) exp_q.push_back({pc, instr});
        end
    endtask

    task automatic drain();
        logic p, q;
        for (int i = 0; i < 2 * DEPTH + 2 && exp_q.size() != 0; i++) begin
            run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, q);
        end
        n_checks++;
        if (bus.count !== '0) begin
            n_fail++;
            $display("FAIL drain_count got %0d exp 0", bus.count);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++;
        if (bus.out_instr !== 32'h0000_0013) begin
            n_fail++; $display("FAIL reset_out_instr got %h exp 00000013", bus.out_instr);
        end
        n_checks++;
        if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
        n_checks++;
        if (bus.out_is_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_is_ctrl got %b exp 0", bus.out_is_ctrl); end
    endtask

    task automatic test_pass_through();
        logic p, q;
        run_cycle(1'b1, 32'h0, 32'h0050_0093, 1'b1, 1'b0, p, q);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got %b exp 1", bus.out_valid); end
        n_checks++;
        if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL pass_pc got %h exp 0", bus.out_pc); end
        n_checks++;
        if (bus.out_instr !== 32'h0050_0093) begin
            n_fail++; $display("FAIL pass_instr got %h exp 00500093", bus.out_instr);
        end
        n_checks++;
        if (bus.out_is_ctrl !== 1'b0) begin n_fail++; $display("FAIL pass_is_ctrl got %b exp 0", bus.out_is_ctrl); end
        run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, p, q);
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL pass_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_fill_stall();
        logic p, q;
        logic accepted;
        int   npop;
        for (int i = 0; i < DEPTH; i++) begin
            run_cycle(1'b1, 32'(i * 4), 32'h0010_0093 + 32'(i << 20), 1'b0, 1'b0, p, q);
        end
        n_checks++;
        if (bus.count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", bus.count, DEPTH); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b exp 0", bus.in_ready); end
        // Held 5th entry while decode stalls
        run_cycle(1'b1, 32'h10, 32'h0050_0113, 1'b0, 1'b0, p, q);
        accepted = 1'b0;
        npop     = 0;
        for (int i = 0; i < 20 && !(accepted && exp_q.size() == 0); i++) begin
            run_cycle(!accepted, 32'h10, 32'h0050_0113, 1'b1, 1'b0, p, q);
            if (p) accepted = 1'b1;
            if (q) npop++;
        end
        n_checks++;
        if (accepted !== 1'b1) begin n_fail++; $display("FAIL fill_held_accepted got %b exp 1", accepted); end
        n_checks++;
        if (npop != DEPTH + 1) begin n_fail++; $display("FAIL fill_pops got %0d exp %0d", npop, DEPTH + 1); end
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL fill_end_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_predecode();
        logic        p, q;
        logic [31:0] instrs [4];
        instrs[0] = 32'h0000_0063;
        instrs[1] = 32'h0000_006F;
        instrs[2] = 32'h0000_0067;
        instrs[3] = 32'h0000_0033;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 32'h40 + 32'(i * 4), instrs[i], 1'b0, 1'b0, p, q);
        end
        n_checks++;
        if (bus.out_is_ctrl !== 1'b1) begin n_fail++; $display("FAIL predecode_beq got %b exp 1", bus.out_is_ctrl); end
        drain();
    endtask

    task automatic test_flush();
        logic p, q;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 32'h80 + 32'(i * 4), 32'h0000_0093, 1'b0, 1'b0, p, q);
        end
        n_checks++;
        if (bus.count !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", bus.count); end
        run_cycle(1'b1, 32'h200, 32'h0000_0063, 1'b1, 1'b1, p, q);
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", bus.count); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
        run_cycle(1'b1, 32'h100, 32'h00a0_0113, 1'b0, 1'b0, p, q);
        n_checks++;
        if (bus.out_pc !== 32'h100) begin n_fail++; $display("FAIL flush_new_pc got %h exp 100", bus.out_pc); end
        n_checks++;
        if (bus.count !== CNT_W'(1)) begin n_fail++; $display("FAIL flush_new_count got %0d exp 1", bus.count); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic p, q;
        run_cycle(1'b1, 32'h400, 32'h0000_0013, 1'b0, 1'b0, p, q);
        for (int i = 1; i <= 8; i++) begin
            run_cycle(1'b1, 32'h400 + 32'(i * 4), 32'h0010_0013 + 32'(i << 7), 1'b1, 1'b0, p, q);
            n_checks++;
            if (bus.count !== CNT_W'(1)) begin
                n_fail++; $display("FAIL b2b_count i=%0d got %0d exp 1", i, bus.count);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic p, q;
        run_cycle(1'b1, 32'h500, 32'h0000_006F, 1'b0, 1'b0, p, q);
        run_cycle(1'b1, 32'h504, 32'h0000_0033, 1'b0, 1'b0, p, q);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h508;
        flush        = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        n_checks++;
        if (bus.count !== '0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", bus.count); end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
        run_cycle(1'b1, 32'h600, 32'h0000_0093, 1'b0, 1'b0, p, q);
        n_checks++;
        if (bus.out_pc !== 32'h600) begin n_fail++; $display("FAIL rstmid_head_pc got %h exp 600", bus.out_pc); end
        drain();
    endtask

    task automatic test_random_stress();
        logic        p, q, iv, ordy, fl, pend;
        logic [31:0] pc, instr, r, next_pc;
        logic [6:0]  opc;
        int          n_full;
        pend    = 1'b0;
        next_pc = 32'h1000;
        iv      = 1'b0;
        pc      = '0;
        instr   = '0;
        n_full  = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!pend) begin
                iv = 1'($urandom_range(0, 1));
                r  = $urandom;
                case ($urandom_range(0, 5))
                    0:       opc = 7'h63;
                    1:       opc = 7'h6F;
                    2:       opc = 7'h67;
                    3:       opc = 7'h33;
                    default: opc = 7'h13;
                endcase
                instr = {r[31:7], opc};
                pc    = next_pc;
            end
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 63) == 0);
            if (exp_q.size() == DEPTH) n_full++;
            run_cycle(iv, pc, instr, ordy, fl, p, q);
            if (p) next_pc = next_pc + 32'd4;
            pend = iv && !p && !fl;
        end
        n_checks++;
        if (n_full == 0) begin n_fail++; $display("FAIL stress_full_seen got %0d exp >0", n_full); end
        drain();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_predecode();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
